// File: rtl/ttc_count_rst_mc.sv
// Multi-channel TTC clock control: per-channel control register, restart
// edge detector and power-of-two prescaler producing count_en_out.
//
// Ports:
//   pclk25           APB system clock
//   n_p_reset25      asynchronous active-low reset
//   pwdata           APB write data (CTRL_W bits)
//   clk_ctrl_reg_sel per-channel write select (several may be set)
//   restart          per-channel restart level
//   count_en_out     per-channel registered counter enable
//   clk_ctrl_reg_out concatenated control regs, ch i at [i*CTRL_W +: CTRL_W]
//
// Option: define TTC_COUNT_RST_RESTART_SYNC_EN to pass each restart bit
// through a 2-flop synchroniser before edge detection.
module ttc_count_rst_mc #(
  parameter int NUM_CH = 3,
  parameter int CTRL_W = 7,
  parameter int PS_W   = 4
) (
  input  logic                     pclk25,
  input  logic                     n_p_reset25,
  input  logic [CTRL_W-1:0]        pwdata,
  input  logic [NUM_CH-1:0]        clk_ctrl_reg_sel,
  input  logic [NUM_CH-1:0]        restart,
  output logic [NUM_CH-1:0]        count_en_out,
  output logic [NUM_CH*CTRL_W-1:0] clk_ctrl_reg_out
);

  localparam int CW = 2**PS_W;

  logic [NUM_CH-1:0] restart_e;

`ifdef TTC_COUNT_RST_RESTART_SYNC_EN
  logic [NUM_CH-1:0] restart_s1;
  logic [NUM_CH-1:0] restart_s2;

  always_ff @(posedge pclk25 or negedge n_p_reset25) begin
    if (!n_p_reset25) begin
      restart_s1 <= '0;
      restart_s2 <= '0;
    end else begin
      restart_s1 <= restart;
      restart_s2 <= restart_s1;
    end
  end

  assign restart_e = restart_s2;
`else
  assign restart_e = restart;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CTRL_W-1:0] ctrl;
    logic [CW-1:0]     ps_cnt;
    logic [CW-1:0]     limit;
    logic [PS_W-1:0]   n;
    logic [PS_W:0]     sh;
    logic              ps_en;
    logic              restart_var;
    logic              count_en;
    logic              clr;

    assign ps_en = ctrl[0];
    assign n     = ctrl[PS_W:1];
    // limit = 2**(N+1)-1; a shift by CW yields all ones
    assign sh    = {1'b0, n} + {{PS_W{1'b0}}, 1'b1};
    assign limit = ~({CW{1'b1}} << sh);

    // A write and a restart edge together form one clear
    assign clr = (restart_e[i] & ~restart_var)
               | clk_ctrl_reg_sel[i];

    always_ff @(posedge pclk25 or negedge n_p_reset25) begin
      if (!n_p_reset25) begin
        ctrl        <= '0;
        ps_cnt      <= '0;
        restart_var <= 1'b0;
        count_en    <= 1'b0;
      end else begin
        if (clk_ctrl_reg_sel[i])
          ctrl <= pwdata;
        restart_var <= restart_e[i];
        if (clr) begin
          count_en <= 1'b0;
          ps_cnt   <= '0;
        end else if (!ps_en) begin
          count_en <= 1'b1;
          ps_cnt   <= '0;
        end else if (ps_cnt == limit) begin
          count_en <= 1'b1;
          ps_cnt   <= '0;
        end else begin
          count_en <= 1'b0;
          ps_cnt   <= ps_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
      end
    end

    assign count_en_out[i] = count_en;
    assign clk_ctrl_reg_out[i*CTRL_W +: CTRL_W] = ctrl;
  end

endmodule

// File: tb/tb_ttc_count_rst_mc.sv
// Randomised bench for ttc_count_rst_mc against a
// cycle-level reference model (edges since last clear).
module tb_ttc_count_rst_mc;

  localparam int NUM_CH = 3;
  localparam int CTRL_W = 7;
  localparam int PS_W   = 4;

  logic                     pclk25;
  logic                     n_p_reset25;
  logic [CTRL_W-1:0]        pwdata;
  logic [NUM_CH-1:0]        clk_ctrl_reg_sel;
  logic [NUM_CH-1:0]        restart;
  logic [NUM_CH-1:0]        count_en_out;
  logic [NUM_CH*CTRL_W-1:0] clk_ctrl_reg_out;

  ttc_count_rst_mc #(
    .NUM_CH(NUM_CH),
    .CTRL_W(CTRL_W),
    .PS_W  (PS_W)
  ) dut (
    .pclk25          (pclk25),
    .n_p_reset25     (n_p_reset25),
    .pwdata          (pwdata),
    .clk_ctrl_reg_sel(clk_ctrl_reg_sel),
    .restart         (restart),
    .count_en_out    (count_en_out),
    .clk_ctrl_reg_out(clk_ctrl_reg_out)
  );

  initial pclk25 = 1'b0;
  always #5 pclk25 = ~pclk25;

  int n_cmp;
  int n_bad;

  // reference state
  logic [CTRL_W-1:0] m_ctrl [NUM_CH];
  longint            m_k    [NUM_CH];
  logic              m_en   [NUM_CH];
  logic              m_prev [NUM_CH];
  logic              m_s1   [NUM_CH];
  logic              m_s2   [NUM_CH];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_ctrl[i] = '0;
      m_k[i]    = 0;
      m_en[i]   = 1'b0;
      m_prev[i] = 1'b0;
      m_s1[i]   = 1'b0;
      m_s2[i]   = 1'b0;
    end
  endtask

  // predict the state after the next rising edge
  task automatic m_edge(input logic [NUM_CH-1:0] s,
                        input logic [CTRL_W-1:0] w,
                        input logic [NUM_CH-1:0] r);
    logic   re;
    logic   clr;
    longint per;
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef TTC_COUNT_RST_RESTART_SYNC_EN
      re = m_s2[i];
`else
      re = r[i];
`endif
      clr       = s[i] | (re & ~m_prev[i]);
      m_prev[i] = re;
      if (clr) begin
        m_k[i]  = 0;
        m_en[i] = 1'b0;
      end else if (m_ctrl[i][0]) begin
        // one pulse every 2**(N+1) edges since the clear
        per     = longint'(1) << (int'(m_ctrl[i][PS_W:1]) + 1);
        m_k[i]  = m_k[i] + 1;
        m_en[i] = (m_k[i] % per) == 0;
      end else begin
        m_en[i] = 1'b1;
      end
      if (s[i]) m_ctrl[i] = w;
      m_s2[i] = m_s1[i];
      m_s1[i] = r[i];
    end
  endtask

  task automatic compare_all(input string tag);
    logic [NUM_CH-1:0]        e_en;
    logic [NUM_CH*CTRL_W-1:0] e_reg;
    for (int i = 0; i < NUM_CH; i++) begin
      e_en[i] = m_en[i];
      e_reg[i*CTRL_W +: CTRL_W] = m_ctrl[i];
    end
    chk({tag, "_en"}, 64'(count_en_out), 64'(e_en));
    chk({tag, "_reg"}, 64'(clk_ctrl_reg_out), 64'(e_reg));
  endtask

  task automatic step(input string tag,
                      input logic [NUM_CH-1:0] s,
                      input logic [CTRL_W-1:0] w,
                      input logic [NUM_CH-1:0] r);
    @(negedge pclk25);
    compare_all(tag);
    clk_ctrl_reg_sel = s;
    pwdata           = w;
    restart          = r;
    m_edge(s, w, r);
  endtask

  task automatic idle(input string tag, input int n,
                      input logic [NUM_CH-1:0] r);
    for (int j = 0; j < n; j++) step(tag, '0, '0, r);
  endtask

  task automatic do_reset();
    @(negedge pclk25);
    #2;
    n_p_reset25 = 1'b0;
    restart = '0;
    clk_ctrl_reg_sel = '0;
    pwdata = '0;
    #1;
    m_reset();
    chk("rst_async_en", 64'(count_en_out), 64'd0);
    chk("rst_async_reg", 64'(clk_ctrl_reg_out), 64'd0);
    @(negedge pclk25);
    @(negedge pclk25);
    chk("rst_hold_en", 64'(count_en_out), 64'd0);
    n_p_reset25 = 1'b1;
    m_edge('0, '0, '0);
  endtask

  logic [NUM_CH-1:0] rr;
  logic [NUM_CH-1:0] ss;
  logic [CTRL_W-1:0] ww;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    n_p_reset25 = 1'b0;
    pwdata = '0;
    clk_ctrl_reg_sel = '0;
    restart = '0;
    m_reset();
    #1;
    chk("reset_en", 64'(count_en_out), 64'd0);
    chk("reset_reg", 64'(clk_ctrl_reg_out), 64'd0);
    @(negedge pclk25);
    n_p_reset25 = 1'b1;
    m_edge('0, '0, '0);

    idle("free", 3, '0);
    // ch1 divide-by-8
    step("wr05", 3'b010, 7'h05, '0);
    idle("div8", 30, '0);
    // ch0 restart held 5 cycles, then low, then again
    idle("rst0", 5, 3'b001);
    idle("rst0lo", 3, '0);
    idle("rst0b", 2, 3'b001);
    idle("rst0blo", 2, '0);
    // ch1 restart mid-period
    idle("pre", 5, '0);
    idle("rst1", 1, 3'b010);
    idle("rst1lo", 20, '0);
    // write ch0/ch2 together with ch0 restart edge
    step("wr01", 3'b101, 7'h01, 3'b001);
    idle("div2", 10, '0);
    // largest divider on ch2 (no pulse inside window)
    step("wrmax", 3'b100, 7'h1f, '0);
    idle("max", 40, '0);
    step("wr0f", 3'b001, 7'h0f, '0);
    idle("div256", 600, '0);

    do_reset();
    idle("post_rst", 4, '0);

    rr = '0;
    for (int c = 0; c < 4000; c++) begin
      ss = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 14) == 0) ss[i] = 1'b1;
        if ($urandom_range(0, 5) == 0) rr[i] = ~rr[i];
      end
      ww[0] = 1'($urandom_range(0, 3) != 0);
      ww[PS_W:1] = ($urandom_range(0, 7) == 0) ?
        PS_W'($urandom_range(0, 15)) :
        PS_W'($urandom_range(0, 3));
      ww[CTRL_W-1:PS_W+1] = 2'($urandom_range(0, 3));
      step("rand", ss, ww, rr);
      if (c == 2000) begin
        do_reset();
        rr = '0;
      end
    end
    @(negedge pclk25);
    compare_all("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
